// File: rtl/alu_fsm.sv
// Sequencer stepping the register file and ALU through one ALU-class instruction.
// Define ALUFSM_UNARY_EN to let unary functions (func 4'b11xx) skip the operand-B load.
module alu_fsm (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_instruction,
    output logic        o_done,
    output logic [4:0]  o_rxOut,
    output logic        o_ALUin0,
    output logic        o_ALUin1,
    output logic        o_ALUoutlatch,
    output logic        o_ALUoutEN,
    output logic [4:0]  o_rxIn,
    output logic        o_pcInc
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD0 = 3'd1,
        LOAD1 = 3'd2,
        EXEC  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_ra;
    logic [4:0] r_rb;
    logic       w_start;
    logic       w_unused;

    // Func and the reserved bit never steer the default sequence.
    assign w_unused = ^{i_instruction[14:11], i_instruction[5]};

    // DONE accepts a new instruction just like IDLE, giving a 5-cycle issue period.
    assign w_start = ((r_state == IDLE) || (r_state == DONE))
                     && i_instruction[15];

`ifdef ALUFSM_UNARY_EN
    logic [3:0] r_func;
    logic       w_unary;

    assign w_unary = (r_func[3:2] == 2'b11);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_ra    <= 5'd0;
            r_rb    <= 5'd0;
`ifdef ALUFSM_UNARY_EN
            r_func  <= 4'd0;
`endif
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_ra   <= i_instruction[10:6];
                r_rb   <= i_instruction[4:0];
`ifdef ALUFSM_UNARY_EN
                r_func <= i_instruction[14:11];
`endif
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        o_done        = 1'b0;
        o_rxOut       = 5'd0;
        o_ALUin0      = 1'b0;
        o_ALUin1      = 1'b0;
        o_ALUoutlatch = 1'b0;
        o_ALUoutEN    = 1'b0;
        o_rxIn        = 5'd0;
        o_pcInc       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_next = w_start ? LOAD0 : IDLE;
            end
            LOAD0: begin
                o_rxOut  = r_ra;
                o_ALUin0 = 1'b1;
`ifdef ALUFSM_UNARY_EN
                w_next   = w_unary ? EXEC : LOAD1;
`else
                w_next   = LOAD1;
`endif
            end
            LOAD1: begin
                o_rxOut  = r_rb;
                o_ALUin1 = 1'b1;
                w_next   = EXEC;
            end
            EXEC: begin
                o_ALUoutlatch = 1'b1;
                w_next        = WRITE;
            end
            WRITE: begin
                o_ALUoutEN = 1'b1;
                o_rxIn     = r_ra;
                w_next     = DONE;
            end
            DONE: begin
                o_done  = 1'b1;
                o_pcInc = 1'b1;
                w_next  = w_start ? LOAD0 : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_fsm.sv
// Directed-vector bench for alu_fsm; outputs sampled on the falling edge.
// Unary-path expectations follow ALUFSM_UNARY_EN when the bench is built with it.
module tb_alu_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        done, a0, a1, lat, en, pc;
    logic [4:0]  rx_out, rx_in;
    logic [15:0] obs;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_fsm dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_instruction (instr),
        .o_done        (done),
        .o_rxOut       (rx_out),
        .o_ALUin0      (a0),
        .o_ALUin1      (a1),
        .o_ALUoutlatch (lat),
        .o_ALUoutEN    (en),
        .o_rxIn        (rx_in),
        .o_pcInc       (pc)
    );

    assign obs = {done, rx_out, a0, a1, lat, en, rx_in, pc};

    function automatic logic [15:0] pk(
        input logic d, input logic [4:0] ro, input logic s0,
        input logic s1, input logic lt, input logic oe,
        input logic [4:0] ri, input logic p);
        return {d, ro, s0, s1, lt, oe, ri, p};
    endfunction

    task automatic test_reset();
        rst   = 1'b1;
        instr = 16'h0000;
        @(negedge clk);
        if (obs !== 16'h0000) begin
            $display("FAIL reset_in: got %h want 0000", obs);
            n_err++;
        end
        n_vec++;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (obs !== 16'h0000) begin
                $display("FAIL reset_idle%0d: got %h want 0000", k, obs);
                n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp [7];
        exp[0] = pk(0, 5'd1, 1, 0, 0, 0, 5'd0, 0);
        exp[1] = pk(0, 5'd2, 0, 1, 0, 0, 5'd0, 0);
        exp[2] = pk(0, 5'd0, 0, 0, 1, 0, 5'd0, 0);
        exp[3] = pk(0, 5'd0, 0, 0, 0, 1, 5'd1, 0);
        exp[4] = pk(1, 5'd0, 0, 0, 0, 0, 5'd0, 1);
        exp[5] = 16'h0000;
        exp[6] = 16'h0000;
        instr = 16'h8042;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) instr = 16'h0000;
            if (obs !== exp[k]) begin
                $display("FAIL basic_c%0d: got %h want %h", k, obs, exp[k]);
                n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_change();
        logic [15:0] exp [11];
        exp[0]  = pk(0, 5'd1, 1, 0, 0, 0, 5'd0, 0);
        exp[1]  = pk(0, 5'd2, 0, 1, 0, 0, 5'd0, 0);
        exp[2]  = pk(0, 5'd0, 0, 0, 1, 0, 5'd0, 0);
        exp[3]  = pk(0, 5'd0, 0, 0, 0, 1, 5'd1, 0);
        exp[4]  = pk(1, 5'd0, 0, 0, 0, 0, 5'd0, 1);
        exp[5]  = pk(0, 5'd3, 1, 0, 0, 0, 5'd0, 0);
        exp[6]  = pk(0, 5'd5, 0, 1, 0, 0, 5'd0, 0);
        exp[7]  = pk(0, 5'd0, 0, 0, 1, 0, 5'd0, 0);
        exp[8]  = pk(0, 5'd0, 0, 0, 0, 1, 5'd3, 0);
        exp[9]  = pk(1, 5'd0, 0, 0, 0, 0, 5'd0, 1);
        exp[10] = 16'h0000;
        instr = 16'h8042;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k == 2) instr = 16'h80C5;
            if (k == 5) instr = 16'h0000;
            if (obs !== exp[k]) begin
                $display("FAIL change_c%0d: got %h want %h", k, obs, exp[k]);
                n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_rst_mid();
        instr = 16'h8042;
        @(negedge clk);
        instr = 16'h0000;
        @(negedge clk);
        if (obs !== pk(0, 5'd2, 0, 1, 0, 0, 5'd0, 0)) begin
            $display("FAIL rstmid_load1: got %h want %h", obs,
                     pk(0, 5'd2, 0, 1, 0, 0, 5'd0, 0));
            n_err++;
        end
        n_vec++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (obs !== 16'h0000) begin
                $display("FAIL rstmid_idle%0d: got %h want 0000", k, obs);
                n_err++;
            end
            n_vec++;
            @(negedge clk);
        end
        rst   = 1'b1;
        instr = 16'h8042;
        @(negedge clk);
        if (obs !== 16'h0000) begin
            $display("FAIL rst_dominates: got %h want 0000", obs);
            n_err++;
        end
        n_vec++;
        instr = 16'h0000;
        rst   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic want;
        instr = 16'h8042;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 15) instr = 16'h0000;
            want = (k % 5 == 0);
            if (done !== want || pc !== want) begin
                $display("FAIL b2b_c%0d: got done=%b pcInc=%b want %b",
                         k, done, pc, want);
                n_err++;
            end
            n_vec++;
        end
        @(negedge clk);
        if (obs !== 16'h0000) begin
            $display("FAIL b2b_stop: got %h want 0000", obs);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_unary();
        logic [15:0] exp [6];
        int          len;
`ifdef ALUFSM_UNARY_EN
        exp[0] = pk(0, 5'd1, 1, 0, 0, 0, 5'd0, 0);
        exp[1] = pk(0, 5'd0, 0, 0, 1, 0, 5'd0, 0);
        exp[2] = pk(0, 5'd0, 0, 0, 0, 1, 5'd1, 0);
        exp[3] = pk(1, 5'd0, 0, 0, 0, 0, 5'd0, 1);
        exp[4] = 16'h0000;
        exp[5] = 16'h0000;
        len    = 5;
`else
        exp[0] = pk(0, 5'd1, 1, 0, 0, 0, 5'd0, 0);
        exp[1] = pk(0, 5'd0, 0, 1, 0, 0, 5'd0, 0);
        exp[2] = pk(0, 5'd0, 0, 0, 1, 0, 5'd0, 0);
        exp[3] = pk(0, 5'd0, 0, 0, 0, 1, 5'd1, 0);
        exp[4] = pk(1, 5'd0, 0, 0, 0, 0, 5'd0, 1);
        exp[5] = 16'h0000;
        len    = 6;
`endif
        instr = 16'hE040;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0) instr = 16'h0000;
            if (obs !== exp[k]) begin
                $display("FAIL unary_c%0d: got %h want %h", k, obs, exp[k]);
                n_err++;
            end
            n_vec++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (32'(a0) + 32'(a1) + 32'(lat) + 32'(en)) > 1) begin
            $display("FAIL strobe_onehot: got %b%b%b%b want at most one",
                     a0, a1, lat, en);
            n_err++;
        end
    end

    initial begin
        rst   = 1'b1;
        instr = 16'h0000;
        @(negedge clk);
        test_reset();
        test_basic();
        test_change();
        test_rst_mid();
        test_back_to_back();
        test_unary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
